// File: rtl/pipeline_control_irq_request.sv
// IRQ request sequencer: latch one request, freeze, drain, call, jump.
// Optional CALL_WAIT watchdog: define PIPELINE_CONTROL_IRQ_TIMEOUT_EN.
module pipeline_control_irq_request #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
   parameter logic [31:0] FAULT_VECTOR   = 32'h0000_0000
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iIRQ_ENA,
   input  logic        iEXCEPT_VALID,
   input  logic [6:0]  iEXCEPT_NUM,
   input  logic        iEXT_IRQ_VALID,
   input  logic [6:0]  iEXT_IRQ_NUM,
   output logic        oEXT_IRQ_ACK,
   input  logic        iPIPELINE_EMPTY,
   output logic        oPIPELINE_STOP,
   output logic        oCALL_START,
   output logic [6:0]  oCALL_NUM,
   input  logic        iCALL_FINISH,
   input  logic [31:0] iCALL_HUNDLER,
   output logic        oJUMP_VALID,
   output logic [31:0] oJUMP_ADDR,
   output logic        oBUSY,
   output logic        oTIMEOUT
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_STOP_WAIT  = 3'd1,
      S_CALL_START = 3'd2,
      S_CALL_WAIT  = 3'd3,
      S_JUMP       = 3'd4
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [6:0]  num;
   logic [6:0]  num_n;
   logic [31:0] hdl;
   logic [31:0] hdl_n;
   logic        stop_q;
   logic        ack;
   logic        tmo;

   // handler low bits are dropped: targets are word aligned
   logic        unused_hdl_bits;
   assign unused_hdl_bits = ^iCALL_HUNDLER[1:0];

`ifdef PIPELINE_CONTROL_IRQ_TIMEOUT_EN
   logic [15:0] cnt;
   logic        expire;

   assign expire = (cnt == TIMEOUT_CYCLES - 16'd1);

   // CALL_WAIT watchdog: cleared at call start, counts unfinished waits
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         cnt <= 16'd0;
      end else if (iRESET_SYNC) begin
         cnt <= 16'd0;
      end else if (state == S_CALL_START) begin
         cnt <= 16'd0;
      end else if (state == S_CALL_WAIT && !iCALL_FINISH) begin
         cnt <= cnt + 16'd1;
      end
   end
`else
   logic        expire;
   logic        unused_params;

   assign expire        = 1'b0;
   assign unused_params = ^{TIMEOUT_CYCLES, FAULT_VECTOR};
`endif

   // next-state, latch selection and combinational pulses
   always_comb begin
      state_n = state;
      num_n   = num;
      hdl_n   = hdl;
      ack     = 1'b0;
      tmo     = 1'b0;
      case (state)
         S_IDLE: begin
            if (iEXCEPT_VALID) begin
               num_n   = iEXCEPT_NUM;
               state_n = S_STOP_WAIT;
            end else if (iEXT_IRQ_VALID && iIRQ_ENA) begin
               ack     = 1'b1;
               num_n   = iEXT_IRQ_NUM;
               state_n = S_STOP_WAIT;
            end
         end
         S_STOP_WAIT: begin
            if (iPIPELINE_EMPTY) begin
               state_n = S_CALL_START;
            end
         end
         S_CALL_START: begin
            state_n = S_CALL_WAIT;
         end
         S_CALL_WAIT: begin
            if (iCALL_FINISH) begin
               hdl_n   = {iCALL_HUNDLER[31:2], 2'b00};
               state_n = S_JUMP;
            end else if (expire) begin
`ifdef PIPELINE_CONTROL_IRQ_TIMEOUT_EN
               hdl_n   = FAULT_VECTOR;
`endif
               tmo     = 1'b1;
               state_n = S_JUMP;
            end
         end
         S_JUMP: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // state, latched vector, handler and registered stop
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state  <= S_IDLE;
         num    <= 7'd0;
         hdl    <= 32'd0;
         stop_q <= 1'b0;
      end else if (iRESET_SYNC) begin
         state  <= S_IDLE;
         num    <= 7'd0;
         hdl    <= 32'd0;
         stop_q <= 1'b0;
      end else begin
         state  <= state_n;
         num    <= num_n;
         hdl    <= hdl_n;
         stop_q <= (state_n != S_IDLE);
      end
   end

   assign oEXT_IRQ_ACK   = ack & ~iRESET_SYNC;
   assign oTIMEOUT       = tmo & ~iRESET_SYNC;
   assign oPIPELINE_STOP = stop_q;
   assign oCALL_START    = (state == S_CALL_START);
   assign oCALL_NUM      = num;
   assign oJUMP_VALID    = (state == S_JUMP);
   assign oJUMP_ADDR     = hdl;
   assign oBUSY          = (state != S_IDLE);

endmodule

// File: tb/tb_pipeline_control_irq_request.sv
// Directed bench for pipeline_control_irq_request.
// Define PIPELINE_CONTROL_IRQ_TIMEOUT_EN to check the watchdog path.
module tb_pipeline_control_irq_request;

   logic        iCLOCK = 1'b0;
   logic        inRESET = 1'b0;
   logic        iRESET_SYNC = 1'b0;
   logic        iIRQ_ENA = 1'b0;
   logic        iEXCEPT_VALID = 1'b0;
   logic [6:0]  iEXCEPT_NUM = 7'd0;
   logic        iEXT_IRQ_VALID = 1'b0;
   logic [6:0]  iEXT_IRQ_NUM = 7'd0;
   logic        oEXT_IRQ_ACK;
   logic        iPIPELINE_EMPTY = 1'b0;
   logic        oPIPELINE_STOP;
   logic        oCALL_START;
   logic [6:0]  oCALL_NUM;
   logic        iCALL_FINISH = 1'b0;
   logic [31:0] iCALL_HUNDLER = 32'd0;
   logic        oJUMP_VALID;
   logic [31:0] oJUMP_ADDR;
   logic        oBUSY;
   logic        oTIMEOUT;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] FV = 32'h0000_0F00;

   pipeline_control_irq_request #(
      .TIMEOUT_CYCLES (16'd8),
      .FAULT_VECTOR   (FV)
   ) dut (
      .iCLOCK          (iCLOCK),
      .inRESET         (inRESET),
      .iRESET_SYNC     (iRESET_SYNC),
      .iIRQ_ENA        (iIRQ_ENA),
      .iEXCEPT_VALID   (iEXCEPT_VALID),
      .iEXCEPT_NUM     (iEXCEPT_NUM),
      .iEXT_IRQ_VALID  (iEXT_IRQ_VALID),
      .iEXT_IRQ_NUM    (iEXT_IRQ_NUM),
      .oEXT_IRQ_ACK    (oEXT_IRQ_ACK),
      .iPIPELINE_EMPTY (iPIPELINE_EMPTY),
      .oPIPELINE_STOP  (oPIPELINE_STOP),
      .oCALL_START     (oCALL_START),
      .oCALL_NUM       (oCALL_NUM),
      .iCALL_FINISH    (iCALL_FINISH),
      .iCALL_HUNDLER   (iCALL_HUNDLER),
      .oJUMP_VALID     (oJUMP_VALID),
      .oJUMP_ADDR      (oJUMP_ADDR),
      .oBUSY           (oBUSY),
      .oTIMEOUT        (oTIMEOUT)
   );

   always #5 iCLOCK = ~iCLOCK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change right after the falling edge, checks 1 time unit later
   task automatic nx();
      @(negedge iCLOCK);
   endtask

   initial begin
      // async reset state
      #1;
      chk("rst_stop", 32'(oPIPELINE_STOP), 0);
      chk("rst_busy", 32'(oBUSY), 0);
      chk("rst_num", 32'(oCALL_NUM), 0);
      chk("rst_addr", oJUMP_ADDR, 0);
      chk("rst_jv", 32'(oJUMP_VALID), 0);
      chk("rst_tmo", 32'(oTIMEOUT), 0);
      nx();
      inRESET = 1'b1;

      // ext IRQ 21h, pipeline empty, finish in first CALL_WAIT cycle
      nx();
      iIRQ_ENA = 1'b1; iPIPELINE_EMPTY = 1'b1;
      iEXT_IRQ_VALID = 1'b1; iEXT_IRQ_NUM = 7'h21;
      #1;
      chk("t1_c0_ack", 32'(oEXT_IRQ_ACK), 1);
      chk("t1_c0_stop", 32'(oPIPELINE_STOP), 0);
      nx();
      iEXT_IRQ_VALID = 1'b0;
      #1;
      chk("t1_c1_stop", 32'(oPIPELINE_STOP), 1);
      chk("t1_c1_cs", 32'(oCALL_START), 0);
      chk("t1_c1_ack", 32'(oEXT_IRQ_ACK), 0);
      nx(); #1;
      chk("t1_c2_cs", 32'(oCALL_START), 1);
      chk("t1_c2_num", 32'(oCALL_NUM), 32'h21);
      chk("t1_c2_stop", 32'(oPIPELINE_STOP), 1);
      nx();
      iCALL_FINISH = 1'b1; iCALL_HUNDLER = 32'h0000_4000;
      #1;
      chk("t1_c3_cs", 32'(oCALL_START), 0);
      chk("t1_c3_jv", 32'(oJUMP_VALID), 0);
      chk("t1_c3_stop", 32'(oPIPELINE_STOP), 1);
      nx();
      iCALL_FINISH = 1'b0;
      #1;
      chk("t1_c4_jv", 32'(oJUMP_VALID), 1);
      chk("t1_c4_addr", oJUMP_ADDR, 32'h4000);
      chk("t1_c4_stop", 32'(oPIPELINE_STOP), 1);
      nx(); #1;
      chk("t1_c5_jv", 32'(oJUMP_VALID), 0);
      chk("t1_c5_stop", 32'(oPIPELINE_STOP), 0);
      chk("t1_c5_busy", 32'(oBUSY), 0);
      chk("t1_c5_hold", oJUMP_ADDR, 32'h4000);

      // exception 05h beats ext IRQ 30h; held IRQ acked after the jump
      nx();
      iEXCEPT_VALID = 1'b1; iEXCEPT_NUM = 7'h05;
      iEXT_IRQ_VALID = 1'b1; iEXT_IRQ_NUM = 7'h30;
      #1;
      chk("t2_c0_ack", 32'(oEXT_IRQ_ACK), 0);
      nx();
      iEXCEPT_VALID = 1'b0;
      #1;
      chk("t2_c1_num", 32'(oCALL_NUM), 32'h05);
      chk("t2_c1_ack", 32'(oEXT_IRQ_ACK), 0);
      nx(); #1;
      chk("t2_c2_cs", 32'(oCALL_START), 1);
      nx();
      iCALL_FINISH = 1'b1; iCALL_HUNDLER = 32'h0000_0100;
      #1;
      chk("t2_c3_ack", 32'(oEXT_IRQ_ACK), 0);
      nx();
      iCALL_FINISH = 1'b0;
      #1;
      chk("t2_c4_jv", 32'(oJUMP_VALID), 1);
      chk("t2_c4_addr", oJUMP_ADDR, 32'h100);
      chk("t2_c4_ack", 32'(oEXT_IRQ_ACK), 0);
      nx(); #1;
      chk("t2_c5_ack", 32'(oEXT_IRQ_ACK), 1);
      chk("t2_c5_busy", 32'(oBUSY), 0);
      nx();
      iEXT_IRQ_VALID = 1'b0;
      #1;
      chk("t2_c6_num", 32'(oCALL_NUM), 32'h30);
      nx(); #1;
      chk("t2_c7_cs", 32'(oCALL_START), 1);
      nx();
      iCALL_FINISH = 1'b1; iCALL_HUNDLER = 32'h0000_0200;
      nx();
      iCALL_FINISH = 1'b0;
      #1;
      chk("t2_c9_addr", oJUMP_ADDR, 32'h200);
      nx(); #1;
      chk("t2_c10_busy", 32'(oBUSY), 0);

      // ext IRQ masked by ENA=0
      iIRQ_ENA = 1'b0;
      iEXT_IRQ_VALID = 1'b1; iEXT_IRQ_NUM = 7'h11;
      for (int i = 0; i < 10; i++) begin
         nx(); #1;
         chk("t3_mask_ack", 32'(oEXT_IRQ_ACK), 0);
         chk("t3_mask_busy", 32'(oBUSY), 0);
      end

      // exception 02h is not masked; pipeline not draining for 20 cycles
      nx();
      iEXT_IRQ_VALID = 1'b0;
      iEXCEPT_VALID = 1'b1; iEXCEPT_NUM = 7'h02;
      iPIPELINE_EMPTY = 1'b0;
      nx();
      iEXCEPT_VALID = 1'b0;
      #1;
      chk("t3_exc_busy", 32'(oBUSY), 1);
      chk("t3_exc_num", 32'(oCALL_NUM), 32'h02);
      for (int i = 0; i < 19; i++) begin
         nx(); #1;
         chk("t4_drain_stop", 32'(oPIPELINE_STOP), 1);
         chk("t4_drain_cs", 32'(oCALL_START), 0);
      end
      nx();
      iPIPELINE_EMPTY = 1'b1;
      #1;
      chk("t4_last_cs", 32'(oCALL_START), 0);
      nx(); #1;
      chk("t4_cs", 32'(oCALL_START), 1);
      nx();
      iCALL_FINISH = 1'b1; iCALL_HUNDLER = 32'h0000_1237;
      nx();
      iCALL_FINISH = 1'b0;
      #1;
      chk("t5_align_jv", 32'(oJUMP_VALID), 1);
      chk("t5_align", oJUMP_ADDR, 32'h1234);
      nx(); #1;
      chk("t5_idle", 32'(oBUSY), 0);

      // sync reset in CALL_WAIT aborts without a jump
      iIRQ_ENA = 1'b1;
      iEXT_IRQ_VALID = 1'b1; iEXT_IRQ_NUM = 7'h0A;
      nx();
      iEXT_IRQ_VALID = 1'b0;
      nx();
      nx();
      #1;
      chk("t6_in_wait", 32'(oBUSY), 1);
      iRESET_SYNC = 1'b1;
      nx();
      iRESET_SYNC = 1'b0;
      iCALL_FINISH = 1'b1; iCALL_HUNDLER = 32'h0000_8000;
      #1;
      chk("t6_busy", 32'(oBUSY), 0);
      chk("t6_stop", 32'(oPIPELINE_STOP), 0);
      chk("t6_num", 32'(oCALL_NUM), 0);
      chk("t6_addr", oJUMP_ADDR, 0);
      for (int i = 0; i < 3; i++) begin
         nx(); #1;
         chk("t6_no_jv", 32'(oJUMP_VALID), 0);
      end
      iCALL_FINISH = 1'b0;

      // no finish: watchdog fires, or waits forever without it
      nx();
      iEXT_IRQ_VALID = 1'b1; iEXT_IRQ_NUM = 7'h33;
      nx();
      iEXT_IRQ_VALID = 1'b0;
      nx();
      #1;
      chk("t7_cs", 32'(oCALL_START), 1);
`ifdef PIPELINE_CONTROL_IRQ_TIMEOUT_EN
      for (int i = 1; i <= 7; i++) begin
         nx(); #1;
         chk("t7_pre_tmo", 32'(oTIMEOUT), 0);
         chk("t7_pre_busy", 32'(oBUSY), 1);
      end
      nx(); #1;
      chk("t7_tmo", 32'(oTIMEOUT), 1);
      nx(); #1;
      chk("t7_tmo_jv", 32'(oJUMP_VALID), 1);
      chk("t7_tmo_addr", oJUMP_ADDR, FV);
      chk("t7_tmo_off", 32'(oTIMEOUT), 0);
      nx(); #1;
      chk("t7_tmo_idle", 32'(oBUSY), 0);
`else
      for (int i = 0; i < 40; i++) begin
         nx(); #1;
         chk("t7_wait_busy", 32'(oBUSY), 1);
         chk("t7_wait_tmo", 32'(oTIMEOUT), 0);
         chk("t7_wait_jv", 32'(oJUMP_VALID), 0);
      end
      iRESET_SYNC = 1'b1;
      nx();
      iRESET_SYNC = 1'b0;
      #1;
      chk("t7_abort", 32'(oBUSY), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
